// File: rtl/ps2_mouse_pkg.sv
// ---------------------------------------------------------------------------
// ps2_mouse_pkg
// Shared types and constants for the PS/2 mouse host sequencer.
//   state_e      : sequencer states (init handshake, stream framing, error)
//   CMD_* / RSP_*: PS/2 mouse command and response bytes
//   mouse_pkt_t  : one decoded stream packet (signed 9-bit deltas + buttons)
//   satDelta     : builds one 9-bit delta, saturating when the overflow bit is set
// ---------------------------------------------------------------------------
package ps2_mouse_pkg;

  typedef enum logic [3:0] {
    ST_SEND_RST,
    ST_W_ACK_RST,
    ST_W_BAT,
    ST_W_ID,
    ST_SEND_EN,
    ST_W_ACK_EN,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_ERROR
  } state_e;

  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_EN_STREAM = 8'hF4;
  localparam logic [7:0] RSP_ACK       = 8'hFA;
  localparam logic [7:0] RSP_RESEND    = 8'hFE;
  localparam logic [7:0] RSP_ERR       = 8'hFC;
  localparam logic [7:0] RSP_BAT_OK    = 8'hAA;
  localparam logic [7:0] RSP_ID_STD    = 8'h00;

  typedef struct packed {
    logic [8:0] dx;
    logic [8:0] dy;
    logic [2:0] btn;
  } mouse_pkt_t;

  // An overflowed axis is clamped to the extreme of its sign:
  // negative -> -256 (9'h100), positive -> +255 (9'h0FF).
  function automatic logic [8:0] satDelta(input logic ovf, input logic sign,
                                          input logic [7:0] mag);
    logic [8:0] result;
    if (ovf) begin
      result = sign ? 9'h100 : 9'h0FF;
    end else begin
      result = {sign, mag};
    end
    return result;
  endfunction

endpackage

// File: rtl/ps2_mouse_ctrl_pkt_decode.sv
// ---------------------------------------------------------------------------
// ps2_mouse_pkt_decode
// Purely combinational decode of the three stream-packet bytes into deltas
// and buttons, including overflow saturation.
// Ports:
//   i_byte0 in  8  status byte {yovf,xovf,ysign,xsign,1,mid,right,left}
//   i_byte1 in  8  X magnitude byte
//   i_byte2 in  8  Y magnitude byte
//   o_pkt   out    decoded mouse_pkt_t
// ---------------------------------------------------------------------------
module ps2_mouse_pkt_decode
  import ps2_mouse_pkg::*;
(
  input  logic [7:0] i_byte0,
  input  logic [7:0] i_byte1,
  input  logic [7:0] i_byte2,
  output mouse_pkt_t o_pkt
);

  // X uses overflow bit 6 and sign bit 4, Y uses overflow bit 7 and sign bit 5.
  always_comb begin
    o_pkt     = '0;
    o_pkt.dx  = satDelta(i_byte0[6], i_byte0[4], i_byte1);
    o_pkt.dy  = satDelta(i_byte0[7], i_byte0[5], i_byte2);
    o_pkt.btn = i_byte0[2:0];
  end

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_mouse_ctrl
// Host-side PS/2 mouse sequencer between a byte-level PHY and the position
// accumulator. Runs the init handshake (reset, BAT, ID, enable streaming),
// then frames 3-byte stream packets into signed 9-bit deltas plus buttons.
// Handles resend requests, response timeouts, bounded init retries and
// packet resynchronisation.
// Ports:
//   clk_i         in   1  system clock
//   rst_i         in   1  asynchronous active-high reset
//   tx_data_o     out  8  command byte for the PHY transmitter
//   tx_req_o      out  1  one-cycle pulse: transmit tx_data_o
//   tx_done_i     in   1  one-cycle pulse: PHY finished sending
//   rx_data_i     in   8  received byte
//   rx_valid_i    in   1  one-cycle pulse: rx_data_i valid
//   xm_o          out  9  signed X delta
//   ym_o          out  9  signed Y delta
//   btnm_o        out  3  {middle,right,left}
//   m_done_tick_o out  1  one-cycle pulse: packet outputs updated
//   init_done_o   out  1  high while streaming
//   err_o         out  1  high in ERROR, sticky until reset
// ---------------------------------------------------------------------------
module ps2_mouse_ctrl
  import ps2_mouse_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int INIT_TMO_MS = 500,
  parameter int PKT_GAP_US  = 2000,
  parameter int RETRY_MAX   = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [7:0] tx_data_o,
  output logic       tx_req_o,
  input  logic       tx_done_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [8:0] xm_o,
  output logic [8:0] ym_o,
  output logic [2:0] btnm_o,
  output logic       m_done_tick_o,
  output logic       init_done_o,
  output logic       err_o
);

  // 64-bit math: CLK_FREQ_HZ * INIT_TMO_MS overflows 32 bits at 50 MHz.
  localparam longint INIT_TC_L = (longint'(CLK_FREQ_HZ) * longint'(INIT_TMO_MS)) / 1000;
  localparam longint GAP_TC_L  = (longint'(CLK_FREQ_HZ) * longint'(PKT_GAP_US)) / 1_000_000;
  localparam longint MAX_TC_L  = (INIT_TC_L > GAP_TC_L) ? INIT_TC_L : GAP_TC_L;
  localparam int     TMR_W     = $clog2(MAX_TC_L) + 1;
  localparam logic [TMR_W-1:0] INIT_LAST = TMR_W'(INIT_TC_L - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_TC_L - 1);

  localparam int RTY_W = $clog2(RETRY_MAX + 2);
  localparam logic [RTY_W-1:0] RETRY_LIM = RTY_W'(RETRY_MAX);

  state_e           r_state;
  state_e           w_stateNext;
  logic [TMR_W-1:0] r_timer;
  logic [RTY_W-1:0] r_retryCnt;
  logic             r_issuePending;
  logic             r_txReq;
  logic [7:0]       r_txData;
  logic [7:0]       r_b0;
  logic [7:0]       r_b1;
  logic [8:0]       r_xm;
  logic [8:0]       r_ym;
  logic [2:0]       r_btn;
  logic             r_tick;

  logic             w_rxByte;
  logic             w_initTmo;
  logic             w_gapTmo;
  logic             w_fault;
  logic             w_retryInc;
  logic             w_capB0;
  logic             w_capB1;
  logic             w_emit;
  logic             w_sendEntry;
  logic [7:0]       w_expect;
  state_e           w_advance;
  state_e           w_owner;
  mouse_pkt_t       w_pkt;

  // A tx_done coinciding with rx_valid wins and the byte is dropped.
  assign w_rxByte  = rx_valid_i & ~tx_done_i;
  assign w_initTmo = (r_timer >= INIT_LAST);
  assign w_gapTmo  = (r_timer >= GAP_LAST);

  // Byte 2 is decoded straight from the PHY so the packet registers on the
  // same edge that sees its rx_valid.
  ps2_mouse_pkt_decode u_decode (
    .i_byte0 (r_b0),
    .i_byte1 (r_b1),
    .i_byte2 (rx_data_i),
    .o_pkt   (w_pkt)
  );

  // Per wait-state table: which response is expected, where a match leads,
  // and which SEND state a resend request returns to.
  always_comb begin
    w_expect  = RSP_ACK;
    w_advance = ST_W_BAT;
    w_owner   = ST_SEND_RST;
    case (r_state)
      ST_W_ACK_RST: begin
        w_expect  = RSP_ACK;
        w_advance = ST_W_BAT;
      end
      ST_W_BAT: begin
        w_expect  = RSP_BAT_OK;
        w_advance = ST_W_ID;
      end
      ST_W_ID: begin
        w_expect  = RSP_ID_STD;
        w_advance = ST_SEND_EN;
      end
      ST_W_ACK_EN: begin
        w_expect  = RSP_ACK;
        w_advance = ST_B0;
        w_owner   = ST_SEND_EN;
      end
      default: ;
    endcase
  end

  // Next-state logic. A received byte always takes priority over a timeout
  // in the same cycle; any init fault either restarts the handshake or, once
  // the retry budget is spent, parks the sequencer in ERROR.
  always_comb begin
    w_stateNext = r_state;
    w_fault     = 1'b0;
    w_retryInc  = 1'b0;
    w_capB0     = 1'b0;
    w_capB1     = 1'b0;
    w_emit      = 1'b0;
    case (r_state)
      ST_SEND_RST: if (tx_done_i) w_stateNext = ST_W_ACK_RST;
      ST_SEND_EN:  if (tx_done_i) w_stateNext = ST_W_ACK_EN;
      ST_W_ACK_RST, ST_W_BAT, ST_W_ID, ST_W_ACK_EN: begin
        if (w_rxByte) begin
          if (rx_data_i == w_expect) begin
            w_stateNext = w_advance;
          end else if (rx_data_i == RSP_RESEND) begin
            w_stateNext = w_owner;
          end else begin
            w_fault = 1'b1;
          end
        end else if (w_initTmo) begin
          w_fault = 1'b1;
        end
      end
      ST_B0: begin
        if (w_rxByte && rx_data_i[3]) begin
          w_capB0     = 1'b1;
          w_stateNext = ST_B1;
        end
      end
      ST_B1: begin
        if (w_rxByte) begin
          w_capB1     = 1'b1;
          w_stateNext = ST_B2;
        end else if (w_gapTmo) begin
          w_stateNext = ST_B0;
        end
      end
      ST_B2: begin
        if (w_rxByte) begin
          w_emit      = 1'b1;
          w_stateNext = ST_B0;
        end else if (w_gapTmo) begin
          w_stateNext = ST_B0;
        end
      end
      default: w_stateNext = ST_ERROR;
    endcase
    if (w_fault) begin
      if (r_retryCnt >= RETRY_LIM) begin
        w_stateNext = ST_ERROR;
      end else begin
        w_retryInc  = 1'b1;
        w_stateNext = ST_SEND_RST;
      end
    end
  end

  // A command goes out on every entry into a SEND state, including the very
  // first cycle after reset when the state is already SEND_RST.
  assign w_sendEntry = ((w_stateNext == ST_SEND_RST) || (w_stateNext == ST_SEND_EN)) &&
                       ((w_stateNext != r_state) || r_issuePending);

  // State, shared timeout timer and retry counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= ST_SEND_RST;
      r_timer        <= '0;
      r_retryCnt     <= '0;
      r_issuePending <= 1'b1;
    end else begin
      r_state        <= w_stateNext;
      r_issuePending <= 1'b0;
      if ((w_stateNext != r_state) || w_rxByte) begin
        r_timer <= '0;
      end else if (r_timer != '1) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_retryInc) begin
        r_retryCnt <= r_retryCnt + 1'b1;
      end
    end
  end

  // Transmit request pulse and held command byte.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_txReq  <= 1'b0;
      r_txData <= '0;
    end else begin
      r_txReq <= w_sendEntry;
      if (w_sendEntry) begin
        r_txData <= (w_stateNext == ST_SEND_EN) ? CMD_EN_STREAM : CMD_RESET;
      end
    end
  end

  // Packet byte capture and output registers; outputs hold between packets.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_b0   <= '0;
      r_b1   <= '0;
      r_xm   <= '0;
      r_ym   <= '0;
      r_btn  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= w_emit;
      if (w_capB0) r_b0 <= rx_data_i;
      if (w_capB1) r_b1 <= rx_data_i;
      if (w_emit) begin
        r_xm  <= w_pkt.dx;
        r_ym  <= w_pkt.dy;
        r_btn <= w_pkt.btn;
      end
    end
  end

  assign tx_req_o      = r_txReq;
  assign tx_data_o     = r_txData;
  assign xm_o          = r_xm;
  assign ym_o          = r_ym;
  assign btnm_o        = r_btn;
  assign m_done_tick_o = r_tick;
  assign init_done_o   = (r_state == ST_B0) || (r_state == ST_B1) || (r_state == ST_B2);
  assign err_o         = (r_state == ST_ERROR);

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ps2_mouse_ctrl
// Directed bench for ps2_mouse_ctrl with a scaled-down clock so timeouts are
// short: 10 kHz nominal gives a 50-cycle init timeout and 20-cycle packet gap.
// A small PHY model answers every tx_req_o with tx_done_i and logs the byte.
// ---------------------------------------------------------------------------
module tb_ps2_mouse_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] txData;
  logic       txReq;
  logic       txDone;
  logic [7:0] rxData;
  logic       rxValid;
  logic [8:0] xm;
  logic [8:0] ym;
  logic [2:0] btnm;
  logic       tick;
  logic       initDone;
  logic       err;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] txLog[$];
  int         txIdx = 0;

  ps2_mouse_ctrl #(
    .CLK_FREQ_HZ (10_000),
    .INIT_TMO_MS (5),
    .PKT_GAP_US  (2000),
    .RETRY_MAX   (3)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .tx_data_o     (txData),
    .tx_req_o      (txReq),
    .tx_done_i     (txDone),
    .rx_data_i     (rxData),
    .rx_valid_i    (rxValid),
    .xm_o          (xm),
    .ym_o          (ym),
    .btnm_o        (btnm),
    .m_done_tick_o (tick),
    .init_done_o   (initDone),
    .err_o         (err)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PHY transmitter model: logs each requested byte and reports completion
  // a few cycles later.
  initial begin
    txDone = 1'b0;
    forever begin
      @(negedge clk);
      if (txReq === 1'b1) begin
        txLog.push_back(txData);
        repeat (3) @(negedge clk);
        txDone = 1'b1;
        @(negedge clk);
        txDone = 1'b0;
      end
    end
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One received byte: rx_valid high for exactly one cycle. Returns just
  // after the following falling edge, when registered results are visible.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rxData  = b;
    rxValid = 1'b1;
    @(negedge clk);
    rxValid = 1'b0;
    #1;
  endtask

  // Waits (bounded) for the next command byte, checks it, then lets the
  // PHY model finish the transfer.
  task automatic waitTx(input logic [7:0] expByte, input string tag);
    int found;
    found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(negedge clk);
      #1;
      if (txLog.size() > txIdx) found = 1;
    end
    checkOutput({tag, "_seen"}, found, 1);
    if (found != 0) begin
      checkOutput(tag, txLog[txIdx], expByte);
      txIdx++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic sendPacket(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [8:0] expX,
                            input logic [8:0] expY, input logic [2:0] expBtn,
                            input string tag);
    applyStimulus(b0);
    applyStimulus(b1);
    checkOutput({tag, "_noEarlyTick"}, tick, 1'b0);
    applyStimulus(b2);
    checkOutput({tag, "_tick"}, tick, 1'b1);
    checkOutput({tag, "_xm"}, xm, expX);
    checkOutput({tag, "_ym"}, ym, expY);
    checkOutput({tag, "_btn"}, btnm, expBtn);
    @(negedge clk);
    #1;
    checkOutput({tag, "_tickOneCycle"}, tick, 1'b0);
  endtask

  task automatic runInit(input string tag);
    waitTx(8'hFF, {tag, "_txReset"});
    applyStimulus(8'hFA);
    applyStimulus(8'hAA);
    applyStimulus(8'h00);
    waitTx(8'hF4, {tag, "_txEnable"});
    checkOutput({tag, "_initBeforeAck"}, initDone, 1'b0);
    applyStimulus(8'hFA);
    checkOutput({tag, "_initDone"}, initDone, 1'b1);
  endtask

  initial begin
    int sawTick;
    rst     = 1'b1;
    rxData  = 8'h00;
    rxValid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_txReq", txReq, 1'b0);
    checkOutput("rst_txData", txData, 8'h00);
    checkOutput("rst_xm", xm, 9'h000);
    checkOutput("rst_ym", ym, 9'h000);
    checkOutput("rst_btn", btnm, 3'b000);
    checkOutput("rst_tick", tick, 1'b0);
    checkOutput("rst_initDone", initDone, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] nominal init");
    runInit("init");

    $display("[TB] streaming packets");
    sendPacket(8'h08, 8'h05, 8'h03, 9'h005, 9'h003, 3'b000, "pktPos");
    sendPacket(8'h38, 8'hFB, 8'hFE, 9'h1FB, 9'h1FE, 3'b000, "pktNeg");

    $display("[TB] resync");
    applyStimulus(8'h00);
    checkOutput("resync_drop0", tick, 1'b0);
    applyStimulus(8'h12);
    checkOutput("resync_drop1", tick, 1'b0);
    sendPacket(8'h09, 8'h01, 8'h01, 9'h001, 9'h001, 3'b001, "pktResync");

    $display("[TB] overflow saturation");
    sendPacket(8'h58, 8'h00, 8'h00, 9'h100, 9'h000, 3'b000, "ovfXneg");
    sendPacket(8'h68, 8'h00, 8'h00, 9'h0FF, 9'h100, 3'b000, "ovfXpos");
    sendPacket(8'h88, 8'h00, 8'h00, 9'h000, 9'h0FF, 3'b000, "ovfYpos");

    $display("[TB] packet gap timeout");
    applyStimulus(8'h08);
    applyStimulus(8'h05);
    sawTick = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (tick === 1'b1) sawTick = 1;
    end
    checkOutput("gap_noTick", sawTick, 0);
    sendPacket(8'h08, 8'h02, 8'h02, 9'h002, 9'h002, 3'b000, "pktAfterGap");

    $display("[TB] reset mid-packet");
    applyStimulus(8'h0F);
    rst = 1'b1;
    #1;
    checkOutput("midRst_xm", xm, 9'h000);
    checkOutput("midRst_ym", ym, 9'h000);
    checkOutput("midRst_initDone", initDone, 1'b0);
    checkOutput("midRst_txReq", txReq, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    waitTx(8'hFF, "midRst_txReset");

    $display("[TB] init faults");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    waitTx(8'hFF, "fault_tx1");
    applyStimulus(8'hFE);
    waitTx(8'hFF, "fault_resend");
    waitTx(8'hFF, "fault_retry1");
    waitTx(8'hFF, "fault_retry2");
    waitTx(8'hFF, "fault_retry3");
    checkOutput("fault_errBeforeLimit", err, 1'b0);
    repeat (100) @(negedge clk);
    #1;
    checkOutput("fault_err", err, 1'b1);
    checkOutput("fault_initDone", initDone, 1'b0);
    checkOutput("fault_noMoreTx", txLog.size(), txIdx);
    applyStimulus(8'hFA);
    checkOutput("fault_errSticky", err, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
